// File: rtl/gpu_fill_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared opcodes, FSM state encoding, command field positions
//                and geometry helpers for the GPU fill engine.
//  Revision    : 1.0  initial release
// ============================================================================
package gpu_pkg;

  // Header opcodes (cmd_data[15:0])
  localparam logic [15:0] GPU_OP_SWAP  = 16'd1;
  localparam logic [15:0] GPU_OP_PIXEL = 16'd2;
  localparam logic [15:0] GPU_OP_RECT  = 16'd3;

  // Header / argument field positions
  localparam int GPU_HDR_OP_MSB    = 15;
  localparam int GPU_HDR_COLOR_LSB = 16;
  localparam int GPU_ARG_X_LSB     = 0;
  localparam int GPU_ARG_X_MSB     = 9;
  localparam int GPU_ARG_Y_LSB     = 16;
  localparam int GPU_ARG_Y_MSB     = 25;

  // Coordinate datapath width: wide enough that x0 + w never wraps
  localparam int GPU_COORD_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARG0      = 3'd1,
    ST_ARG1      = 3'd2,
    ST_FILL      = 3'd3,
    ST_SWAP_WAIT = 3'd4
  } gpu_state_e;

  // Pixels per 32-bit VRAM word
  function automatic int gpu_ppw(input int bpp);
    return 32 / bpp;
  endfunction

  // VRAM words per screen row
  function automatic int gpu_wpr(input int width, input int bpp);
    return width / gpu_ppw(bpp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_fill_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_fill_engine_if
//  Description : Command stream and VRAM write port of the fill engine.
//                master : the fill engine (consumes commands, issues writes)
//                slave  : surrounding fabric (command FIFO + VRAM port)
//  Signals     : cmd_valid/cmd_data/cmd_ready  command word handshake
//                vram_we/addr/wdata/wmask/ready masked word write handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface gpu_fill_engine_if #(
  parameter int AW = 19
);
  logic          cmd_valid;
  logic [31:0]   cmd_data;
  logic          cmd_ready;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [31:0]   vram_wdata;
  logic [31:0]   vram_wmask;
  logic          vram_ready;

  modport master (
    input  cmd_valid, cmd_data, vram_ready,
    output cmd_ready, vram_we, vram_addr, vram_wdata, vram_wmask
  );

  modport slave (
    output cmd_valid, cmd_data, vram_ready,
    input  cmd_ready, vram_we, vram_addr, vram_wdata, vram_wmask
  );
endinterface
`default_nettype wire

// File: rtl/gpu_fill_engine_span_mask.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_span_mask
//  Description : Combinational per-bit write mask for one VRAM word. A pixel
//                slot s is enabled when (!lo_en_i || s >= lo_slot_i) and
//                (!hi_en_i || s <= hi_slot_i); each enabled slot sets its
//                BPP bits. Slots are LSB-first.
//  Ports       : lo_slot_i/hi_slot_i  span bounds within the word
//                lo_en_i/hi_en_i      apply lower/upper bound
//                mask_o               32-bit field mask
//  Revision    : 1.0  initial release
// ============================================================================
module gpu_span_mask
  import gpu_pkg::*;
#(
  parameter int BPP = 2
) (
  input  logic [4:0]  lo_slot_i,
  input  logic [4:0]  hi_slot_i,
  input  logic        lo_en_i,
  input  logic        hi_en_i,
  output logic [31:0] mask_o
);

  localparam int c_ppw = gpu_ppw(BPP);

  generate
    for (genvar s = 0; s < c_ppw; s++) begin : g_slot
      logic w_on;
      assign w_on = (!lo_en_i || (5'(s) >= lo_slot_i)) &&
                    (!hi_en_i || (5'(s) <= hi_slot_i));
      assign mask_o[s*BPP +: BPP] = {BPP{w_on}};
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gpu_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_fill_engine
//  Description : Executes PIXEL / RECT / SWAP commands, writing the work
//                framebuffer with masked word writes and owning the
//                double-buffer select. SWAP completes on the feeder's
//                frame_end.
//  Build macro : GPU_FILL_CLIP_EN - clip rects overhanging the screen edge
//                instead of rejecting them.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                bus (master)  command stream + VRAM write port
//                frame_end     feeder fetched last word of frame (pulse)
//                vram_sel      work buffer index (display = ~vram_sel)
//                busy          engine not idle
//                err           command rejected (pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module gpu_fill_engine
  import gpu_pkg::*;
#(
  parameter int BPP    = 2,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int AW     = 19
) (
  input  logic              clk,
  input  logic              rst,
  gpu_fill_engine_if.master bus,
  input  logic              frame_end,
  output logic              vram_sel,
  output logic              busy,
  output logic              err
);

  localparam int                     c_ppw      = gpu_ppw(BPP);
  localparam int                     c_ppw_lg   = $clog2(c_ppw);
  localparam logic [GPU_COORD_W-1:0] c_slot_msk = GPU_COORD_W'(c_ppw - 1);
  localparam logic [GPU_COORD_W-1:0] c_width    = GPU_COORD_W'(WIDTH);
  localparam logic [GPU_COORD_W-1:0] c_height   = GPU_COORD_W'(HEIGHT);
  localparam logic [AW-1:0]          c_wpr      = AW'(gpu_wpr(WIDTH, BPP));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  gpu_state_e             state_q, state_d;
  logic                   rect_q, rect_d;
  logic [BPP-1:0]         color_q, color_d;
  logic [GPU_COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [GPU_COORD_W-1:0] fw_q, fw_d, lw_q, lw_d, col_q, col_d, rows_q, rows_d;
  logic [4:0]             lo_q, lo_d, hi_q, hi_d;
  logic [AW-1:0]          row_base_q, row_base_d, addr_q, addr_d;
  logic                   we_q, we_d, sel_q, sel_d, err_q, err_d;
  logic [31:0]            wdata_q, wdata_d, wmask_q, wmask_d;

  // --------------------------------------------------------------------------
  // Argument validation / span setup (valid only in the final-argument cycle)
  // --------------------------------------------------------------------------
  logic [GPU_COORD_W-1:0] w_arg_x, w_arg_y;
  logic [GPU_COORD_W-1:0] w_vx, w_vy, w_vw, w_vh, w_ew, w_eh, w_xend;
  logic [GPU_COORD_W-1:0] w_fw, w_lw, w_lo_full, w_hi_full;
  logic [4:0]             w_lo, w_hi;
  logic [AW-1:0]          w_row_base;
  logic                   w_arg_done, w_zero, w_oob, w_over_x, w_over_y;
  logic                   w_reject, w_load, w_bad;
  logic                   w_unused_bits;

  assign w_arg_x = {1'b0, bus.cmd_data[GPU_ARG_X_MSB:GPU_ARG_X_LSB]};
  assign w_arg_y = {1'b0, bus.cmd_data[GPU_ARG_Y_MSB:GPU_ARG_Y_LSB]};
  assign w_unused_bits = ^bus.cmd_data[31:26];

  // PIXEL finishes in ARG0 as a 1x1 rect; RECT finishes in ARG1 with the
  // origin already latched and the extent arriving on the bus.
  assign w_arg_done = bus.cmd_valid &&
                      ((state_q == ST_ARG1) || ((state_q == ST_ARG0) && !rect_q));
  assign w_vx = (state_q == ST_ARG1) ? x0_q    : w_arg_x;
  assign w_vy = (state_q == ST_ARG1) ? y0_q    : w_arg_y;
  assign w_vw = (state_q == ST_ARG1) ? w_arg_x : GPU_COORD_W'(1);
  assign w_vh = (state_q == ST_ARG1) ? w_arg_y : GPU_COORD_W'(1);

  assign w_zero   = (w_vw == '0) || (w_vh == '0);
  assign w_oob    = (w_vx >= c_width) || (w_vy >= c_height);
  assign w_over_x = (w_vx + w_vw) > c_width;
  assign w_over_y = (w_vy + w_vh) > c_height;

`ifdef GPU_FILL_CLIP_EN
  assign w_ew     = w_over_x ? (c_width - w_vx)  : w_vw;
  assign w_eh     = w_over_y ? (c_height - w_vy) : w_vh;
  assign w_reject = 1'b0;
`else
  assign w_ew     = w_vw;
  assign w_eh     = w_vh;
  assign w_reject = w_over_x || w_over_y;
`endif

  assign w_load = w_arg_done && !w_zero && !w_oob && !w_reject;
  assign w_bad  = w_arg_done && !w_zero && (w_oob || w_reject);

  assign w_xend     = w_vx + w_ew - GPU_COORD_W'(1);
  assign w_fw       = w_vx >> c_ppw_lg;
  assign w_lw       = w_xend >> c_ppw_lg;
  assign w_lo_full  = w_vx & c_slot_msk;
  assign w_hi_full  = w_xend & c_slot_msk;
  assign w_lo       = w_lo_full[4:0];
  assign w_hi       = w_hi_full[4:0];
  assign w_row_base = AW'(w_vy) * c_wpr;

  // --------------------------------------------------------------------------
  // Mask for the word presented next: either the first word of a new command
  // or the successor of the word being accepted (wrapping to the next row).
  // --------------------------------------------------------------------------
  logic [GPU_COORD_W-1:0] w_m_col, w_m_fw, w_m_lw;
  logic [4:0]             w_m_lo, w_m_hi;
  logic [31:0]            w_mask;

  always_comb begin
    if (w_load) begin
      w_m_col = w_fw;
      w_m_fw  = w_fw;
      w_m_lw  = w_lw;
      w_m_lo  = w_lo;
      w_m_hi  = w_hi;
    end else begin
      w_m_col = (col_q == lw_q) ? fw_q : (col_q + GPU_COORD_W'(1));
      w_m_fw  = fw_q;
      w_m_lw  = lw_q;
      w_m_lo  = lo_q;
      w_m_hi  = hi_q;
    end
  end

  gpu_span_mask #(
    .BPP (BPP)
  ) u_span_mask (
    .lo_slot_i (w_m_lo),
    .hi_slot_i (w_m_hi),
    .lo_en_i   (w_m_col == w_m_fw),
    .hi_en_i   (w_m_col == w_m_lw),
    .mask_o    (w_mask)
  );

  // --------------------------------------------------------------------------
  // FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rect_d     = rect_q;
    color_d    = color_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    fw_d       = fw_q;
    lw_d       = lw_q;
    col_d      = col_q;
    rows_d     = rows_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    err_d      = w_bad;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          color_d = bus.cmd_data[GPU_HDR_COLOR_LSB +: BPP];
          case (bus.cmd_data[GPU_HDR_OP_MSB:0])
            GPU_OP_SWAP:  state_d = ST_SWAP_WAIT;
            GPU_OP_PIXEL: begin rect_d = 1'b0; state_d = ST_ARG0; end
            GPU_OP_RECT:  begin rect_d = 1'b1; state_d = ST_ARG0; end
            default:      err_d = 1'b1;
          endcase
        end
      end
      ST_ARG0: begin
        if (bus.cmd_valid) begin
          x0_d = w_arg_x;
          y0_d = w_arg_y;
          if (rect_q) state_d = ST_ARG1;
          else        state_d = w_load ? ST_FILL : ST_IDLE;
        end
      end
      ST_ARG1: begin
        if (bus.cmd_valid) state_d = w_load ? ST_FILL : ST_IDLE;
      end
      ST_FILL: begin
        if (bus.vram_ready) begin
          if ((col_q == lw_q) && (rows_q == '0)) begin
            we_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            col_d   = w_m_col;
            wmask_d = w_mask;
            if (col_q == lw_q) begin
              rows_d     = rows_q - GPU_COORD_W'(1);
              row_base_d = row_base_q + c_wpr;
              addr_d     = row_base_q + c_wpr + AW'(fw_q);
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end
        end
      end
      ST_SWAP_WAIT: begin
        if (frame_end) begin
          sel_d   = ~sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // First word of an accepted command goes out the cycle after the last
    // argument word.
    if (w_load) begin
      fw_d       = w_fw;
      lw_d       = w_lw;
      lo_d       = w_lo;
      hi_d       = w_hi;
      col_d      = w_fw;
      rows_d     = w_eh - GPU_COORD_W'(1);
      row_base_d = w_row_base;
      addr_d     = w_row_base + AW'(w_fw);
      wdata_d    = {c_ppw{color_q}};
      wmask_d    = w_mask;
      we_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rect_q     <= 1'b0;
      color_q    <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      fw_q       <= '0;
      lw_q       <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rect_q     <= rect_d;
      color_q    <= color_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      fw_q       <= fw_d;
      lw_q       <= lw_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_ARG0) ||
                          (state_q == ST_ARG1);
  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
  assign bus.vram_wmask = wmask_q;
  assign vram_sel       = sel_q;
  assign busy           = (state_q != ST_IDLE);
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpu_fill_engine
//  Description : Directed self-checking bench for gpu_fill_engine
//                (BPP=2, 640x480: 16 pixels/word, 40 words/row).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpu_fill_engine;

  localparam int BPP    = 2;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int AW     = 19;

  logic clk = 1'b0;
  logic rst;
  logic frame_end;
  logic vram_sel, busy, err;

  gpu_fill_engine_if #(.AW(AW)) bus();

  gpu_fill_engine #(
    .BPP    (BPP),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .AW     (AW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_end (frame_end),
    .vram_sel  (vram_sel),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Accepted-write log, sampled mid-cycle
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   m;
    logic [31:0]   d;
    int            c;
  } wr_t;
  wr_t wq[$];
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.vram_we && bus.vram_ready)
      wq.push_back('{a: bus.vram_addr, m: bus.vram_wmask, d: bus.vram_wdata, c: cyc});
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] e2_addr [4] = '{32'd40, 32'd41, 32'd80, 32'd81};
  logic [31:0] e2_mask [4] = '{32'hF000_0000, 32'h0000_000F, 32'hF000_0000, 32'h0000_000F};

  initial begin
    rst           = 1'b1;
    frame_end     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.vram_ready = 1'b1;
    tick(3);

    // ---- reset state ----
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_we",        {31'd0, bus.vram_we},   32'd0);
    check("rst_addr",      32'(bus.vram_addr),     32'd0);
    check("rst_wdata",     bus.vram_wdata,         32'd0);
    check("rst_wmask",     bus.vram_wmask,         32'd0);
    check("rst_sel",       {31'd0, vram_sel},      32'd0);
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_err",       {31'd0, err},           32'd0);
    rst = 1'b0;
    tick(1);

    // ---- PIXEL color 3 at (5,0) ----
    send(32'h0003_0002);
    send(32'h0000_0005);
    check("px_we_lat", {31'd0, bus.vram_we}, 32'd1);
    check("px_addr",   32'(bus.vram_addr),   32'd0);
    check("px_wmask",  bus.vram_wmask,       32'h0000_0C00);
    check("px_wdata",  bus.vram_wdata,       32'hFFFF_FFFF);
    wait_idle();
    check("px_nwr", wq.size(), 32'd1);
    check("px_we_off", {31'd0, bus.vram_we}, 32'd0);
    wq.delete();

    // ---- RECT color 1 (14,1) w=4 h=2 ----
    send(32'h0001_0003);
    send(32'h0001_000E);
    send(32'h0002_0004);
    wait_idle();
    check("r2_nwr", wq.size(), 32'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      check($sformatf("r2_addr%0d", i), 32'(wq[i].a), e2_addr[i]);
      check($sformatf("r2_mask%0d", i), wq[i].m, e2_mask[i]);
      check($sformatf("r2_data%0d", i), wq[i].d, 32'h5555_5555);
    end
    if (wq.size() == 4) check("r2_no_bubble", 32'(wq[3].c - wq[0].c), 32'd3);
    wq.delete();

    // ---- stall mid-row: RECT color 2 (0,3) w=48 h=1 ----
    send(32'h0002_0003);
    send(32'h0003_0000);
    send(32'h0001_0030);
    @(posedge clk);
    #1;
    bus.vram_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_addr",  32'(bus.vram_addr), 32'd121);
      check("stall_wmask", bus.vram_wmask,     32'hFFFF_FFFF);
      check("stall_wdata", bus.vram_wdata,     32'hAAAA_AAAA);
    end
    @(posedge clk);
    #1;
    bus.vram_ready = 1'b1;
    wait_idle();
    check("stall_nwr", wq.size(), 32'd3);
    for (int i = 0; i < 3 && i < wq.size(); i++)
      check($sformatf("stall_wr%0d", i), 32'(wq[i].a), 32'(120 + i));
    wq.delete();

    // ---- SWAP, frame_end coincident with header is ignored ----
    frame_end = 1'b1;
    send(32'h0000_0001);
    frame_end = 1'b0;
    check("swap_ready0", {31'd0, bus.cmd_ready}, 32'd0);
    check("swap_busy",   {31'd0, busy},          32'd1);
    tick(9);
    frame_end = 1'b1;
    @(negedge clk);
    check("swap_sel_pre",    {31'd0, vram_sel},      32'd0);
    check("swap_ready_pre",  {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    frame_end = 1'b0;
    check("swap_sel_post",   {31'd0, vram_sel},      32'd1);
    check("swap_ready_post", {31'd0, bus.cmd_ready}, 32'd1);

    // ---- overhanging RECT (630,470) w=20 h=20 ----
    send(32'h0003_0003);
    send(32'h01D6_0276);
    send(32'h0014_0014);
`ifdef GPU_FILL_CLIP_EN
    check("clip_err", {31'd0, err}, 32'd0);
    wait_idle();
    check("clip_nwr", wq.size(), 32'd10);
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      check($sformatf("clip_addr%0d", i), 32'(wq[i].a), 32'((470 + i) * 40 + 39));
      check($sformatf("clip_mask%0d", i), wq[i].m, 32'hFFFF_F000);
    end
`else
    check("clip_err",   {31'd0, err},  32'd1);
    check("clip_busy",  {31'd0, busy}, 32'd0);
    tick(1);
    check("clip_err_pulse", {31'd0, err}, 32'd0);
    tick(4);
    check("clip_nwr", wq.size(), 32'd0);
`endif
    wq.delete();

    // ---- last pixel (639,479), color 1 ----
    send(32'h0001_0002);
    send(32'h01DF_027F);
    check("lastpx_addr",  32'(bus.vram_addr), 32'd19199);
    check("lastpx_wmask", bus.vram_wmask,     32'hC000_0000);
    wait_idle();
    check("lastpx_nwr", wq.size(), 32'd1);
    wq.delete();

    // ---- bad opcode ----
    send(32'h0000_0007);
    check("op7_err",  {31'd0, err},  32'd1);
    check("op7_busy", {31'd0, busy}, 32'd0);
    tick(1);
    check("op7_err_pulse", {31'd0, err}, 32'd0);

    // ---- zero width: silent drop ----
    send(32'h0001_0003);
    send(32'h0000_0000);
    send(32'h0005_0000);
    check("zw_err",  {31'd0, err},  32'd0);
    check("zw_busy", {31'd0, busy}, 32'd0);

    // ---- pixel off-screen at x=640 ----
    send(32'h0001_0002);
    send(32'h0000_0280);
    check("oob_err", {31'd0, err}, 32'd1);
    tick(3);
    check("oob_nwr", wq.size(), 32'd0);

    // ---- reset mid-RECT (vram_sel currently 1) ----
    send(32'h0001_0003);
    send(32'h0000_0000);
    send(32'h000A_0140);
    tick(5);
    check("mid_we", {31'd0, bus.vram_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_we",    {31'd0, bus.vram_we},   32'd0);
    check("mrst_sel",   {31'd0, vram_sel},      32'd0);
    check("mrst_busy",  {31'd0, busy},          32'd0);
    check("mrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/gpu_fill_engine.md
Name: gpu_fill_engine

Overview:
- Parametrised drawing engine for the GPU: accepts PIXEL, RECT and SWAP commands over a valid/ready word stream and writes the work framebuffer.
- Uses masked word writes, not read-modify-write, and works for any power-of-two pixel depth.
- Owns double-buffer select; SWAP is synchronised to the pixel feeder's end-of-frame.
- Sits between the command FIFO and the two VRAM write ports.

Parameters:
- BPP, 2, bits per pixel (1, 2, 4 or 8).
- WIDTH, 640, screen width in pixels; must be a multiple of 32/BPP.
- HEIGHT, 480, screen height in pixels.
- AW, 19, VRAM word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command word valid.
- cmd_data  in  32  command word.
- cmd_ready  out  1  engine accepts cmd_data this cycle.
- vram_we  out  1  write request.
- vram_addr  out  AW  word address within the work buffer.
- vram_wdata  out  32  color replicated across all pixel slots.
- vram_wmask  out  32  per-bit write enable; whole pixel fields only.
- vram_ready  in  1  write accepted when high with vram_we.
- frame_end  in  1  one-cycle pulse: feeder has fetched the last word of the frame.
- vram_sel  out  1  work buffer index; display buffer is ~vram_sel.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset values: cmd_ready=1, vram_we=0, vram_addr=0, vram_wdata=0, vram_wmask=0, vram_sel=0, busy=0, err=0.
- Derived constants: PPW=32/BPP pixels per word; WPR=WIDTH/PPW words per row. Word addr = y*WPR + x/PPW. Pixel slot = x%PPW at bit offset BPP*slot, LSB-first.
- Header word: [15:0] opcode, [16+BPP-1:16] color.
- Opcodes: 1=SWAP, 2=PIXEL, 3=RECT. Any other opcode: err pulse, stay IDLE, no writes.
- Argument words: {y[25:16], x[9:0]}; for RECT a second word {h[25:16], w[9:0]}.
- cmd_ready=1 in IDLE, ARG0, ARG1; 0 in FILL and SWAP_WAIT.
- States: IDLE, ARG0, ARG1, FILL, SWAP_WAIT.
  - IDLE: a header on cmd_valid goes to ARG0 (PIXEL/RECT) or SWAP_WAIT (SWAP).
  - ARG0: PIXEL -> FILL with w=h=1; RECT -> ARG1.
  - ARG1: validate/clip, then FILL or IDLE.
  - FILL: emit one word per accepted write (vram_we & vram_ready); hold addr/data/mask while vram_ready=0.
    - Row: words first..last. First word masks slots >= x0%PPW; last word masks slots <= (x0+w-1)%PPW; when first==last, both bounds apply.
    - After the last word of the last row -> IDLE; vram_we drops the same edge.
  - SWAP_WAIT: the first frame_end seen in this state toggles vram_sel -> IDLE. A frame_end coincident with header acceptance is ignored.
- Throughput: 1 word/cycle with vram_ready held high; no bubble between rows.
- Latency: first write is presented in the cycle after the final argument is accepted.
- Validation:
  - w==0 or h==0: no writes, -> IDLE, no err.
  - x0>=WIDTH or y0>=HEIGHT: err, -> IDLE.
  - Extent beyond screen: see Optional Feature.
- Coordinate arithmetic uses 11 bits, so x0+w cannot overflow.
- Reset mid-FILL or mid-SWAP_WAIT: abort at the next edge; vram_sel returns to 0.

Optional Feature:
- Macro GPU_FILL_CLIP_EN.
- Defined: a rect with x0+w>WIDTH or y0+h>HEIGHT is clipped to w=WIDTH-x0, h=HEIGHT-y0 and drawn; no err.
- Undefined: such a rect is rejected with an err pulse and produces no writes.

Decomposition:
- Package gpu_pkg:
  - opcode localparams GPU_OP_SWAP/PIXEL/RECT;
  - state enum;
  - PPW/WPR constant functions;
  - argument field bit positions.
- Sub-module gpu_span_mask: combinational; inputs lo_slot, hi_slot, lo_en, hi_en; output 32-bit field mask. Instantiated once.

Test Plan:
- BPP=2: PIXEL color=3 at (5,0) -> one write, addr 0, wmask 0x00000C00, wdata 0xFFFFFFFF.
- RECT color=1 (14,1) w=4 h=2, WIDTH=640 -> rows y=1,2; writes at addr 40 (wmask 0xF0000000) and 41 (wmask 0x0000000F), then addr 80 and 81 with the same masks.
- vram_ready low 3 cycles mid-row -> addr/wdata/wmask stable; no word skipped or duplicated.
- SWAP issued, frame_end after 10 cycles -> vram_sel toggles on that edge; cmd_ready=0 until then.
- RECT (630,470) w=20 h=20 -> with GPU_FILL_CLIP_EN: 10 rows, each ending at x=639; without it: err pulse, no writes.
- Opcode 7 -> err pulse; rst asserted mid-RECT -> vram_we=0 and vram_sel=0 next cycle.
